// File: rtl/alu_pkg.sv
// Shared op encoding and widths for the registered ALU slice.
package alu_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND = 2'd0;
    localparam op_t OP_OR  = 2'd1;
    localparam op_t OP_ADD = 2'd2;
    localparam op_t OP_SLT = 2'd3;

    localparam int unsigned OP_W      = 2;
    localparam int unsigned MAX_WIDTH = 64;

endpackage

// File: rtl/alu_bit.sv
// Combinational 1-bit ALU slice: operand inversion, full adder and result mux.
module alu_bit
    import alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic Ain,
    input  logic Bin,
    input  op_t  Op,
    input  logic cin,
    input  logic less,
    output logic result,
    output logic cout,
    output logic sum
);

    logic a_c;
    logic b_c;

    // Condition operands, add, then select the result.
    always_comb begin
        a_c    = Ain ? ~a : a;
        b_c    = Bin ? ~b : b;
        sum    = a_c ^ b_c ^ cin;
        cout   = (a_c & b_c) | (cin & (a_c ^ b_c));
        result = 1'b0;
        unique case (Op)
            OP_AND:  result = a_c & b_c;
            OP_OR:   result = a_c | b_c;
            OP_ADD:  result = sum;
            OP_SLT:  result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ripple-carry ALU built from a chain of alu_bit slices.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ain,
    input  logic             Bin,
    input  op_t              Op,
    input  logic             Cin,
    input  logic             Less,
    output logic             Cout,
    output logic [WIDTH-1:0] O,
    output logic             Set,
    output logic             Ovf
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] less_vec;

    logic [WIDTH-1:0] o_d,    o_q;
    logic             cout_d, cout_q;
    logic             set_d,  set_q;
    logic             ovf_d,  ovf_q;

    // Only the LSB slice passes Less; upper slices pass zero on SLT.
    assign less_vec = WIDTH'(Less);
    assign carry[0] = Cin;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        alu_bit u_bit (
            .a      (A[i]),
            .b      (B[i]),
            .Ain    (Ain),
            .Bin    (Bin),
            .Op     (Op),
            .cin    (carry[i]),
            .less   (less_vec[i]),
            .result (res[i]),
            .cout   (carry[i+1]),
            .sum    (sum[i])
        );
    end

    // Next-state: result plus flags taken from the MSB slice carries.
    always_comb begin
        o_d    = res;
        cout_d = carry[WIDTH];
        set_d  = sum[WIDTH-1];
        ovf_d  = carry[WIDTH-1] ^ carry[WIDTH];
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q    <= '0;
            cout_q <= 1'b0;
            set_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            o_q    <= o_d;
            cout_q <= cout_d;
            set_q  <= set_d;
            ovf_q  <= ovf_d;
        end
    end

    assign O    = o_q;
    assign Cout = cout_q;
    assign Set  = set_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: WIDTH=1 and WIDTH=8 instances, vector table plus scoreboarded random run.
module tb_alu;

    typedef struct {
        string      name;
        logic       w8;
        logic       rst;
        logic [7:0] a;
        logic [7:0] b;
        logic       ain;
        logic       bin;
        logic [1:0] op;
        logic       cin;
        logic       less;
        logic [7:0] o;
        logic       cout;
        logic       set;
        logic       ovf;
    } vec_t;

    typedef struct {
        string      name;
        logic       w8;
        logic [7:0] o;
        logic       cout;
        logic       set;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_i, b_i;
    logic       ain_i, bin_i, cin_i, less_i;
    logic [1:0] op_i;
    logic [0:0] a1, b1, o1;
    logic [7:0] o8;
    logic       cout1, set1, ovf1, cout8, set8, ovf8;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vq[$];
    exp_t sb[$];

    assign a1 = a_i[0:0];
    assign b1 = b_i[0:0];

    always #5 clk = ~clk;

    alu #(.WIDTH(1)) u_alu1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Ain(ain_i), .Bin(bin_i),
        .Op(op_i), .Cin(cin_i), .Less(less_i),
        .Cout(cout1), .O(o1), .Set(set1), .Ovf(ovf1)
    );

    alu #(.WIDTH(8)) u_alu8 (
        .clk(clk), .rst(rst), .A(a_i), .B(b_i), .Ain(ain_i), .Bin(bin_i),
        .Op(op_i), .Cin(cin_i), .Less(less_i),
        .Cout(cout8), .O(o8), .Set(set8), .Ovf(ovf8)
    );

    // Independent arithmetic reference for either width.
    function automatic exp_t model(input string nm, input logic w8, input logic r,
                                   input logic [7:0] a, input logic [7:0] b,
                                   input logic ain, input logic bin, input logic [1:0] op,
                                   input logic cin, input logic less);
        exp_t       e;
        int         w;
        logic [8:0] mask, lowmask, aa, bb, full, low;
        w       = w8 ? 8 : 1;
        mask    = (9'd1 << w) - 9'd1;
        lowmask = mask >> 1;
        aa      = {1'b0, (ain ? ~a : a)} & mask;
        bb      = {1'b0, (bin ? ~b : b)} & mask;
        full    = aa + bb + 9'(cin);
        low     = (aa & lowmask) + (bb & lowmask) + 9'(cin);
        e.name  = nm;
        e.w8    = w8;
        e.cout  = full[w];
        e.set   = full[w-1];
        e.ovf   = low[w-1] ^ full[w];
        case (op)
            2'd0:    e.o = 8'(aa & bb);
            2'd1:    e.o = 8'(aa | bb);
            2'd2:    e.o = 8'(full & mask);
            default: e.o = {7'd0, less};
        endcase
        if (r) begin
            e.o = 8'd0; e.cout = 1'b0; e.set = 1'b0; e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input string f, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s got=%h expected=%h at %0t", nm, f, got, exp, $time);
        end
    endtask

    // Pop every queued expectation and compare against the matching instance.
    task automatic check_sb();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_empty got=0 expected>0 at %0t", $time);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.w8) begin
                cmp(e.name, "O",    o8,          e.o);
                cmp(e.name, "Cout", 8'(cout8),   8'(e.cout));
                cmp(e.name, "Set",  8'(set8),    8'(e.set));
                cmp(e.name, "Ovf",  8'(ovf8),    8'(e.ovf));
            end else begin
                cmp(e.name, "O",    8'(o1),      8'(e.o[0]));
                cmp(e.name, "Cout", 8'(cout1),   8'(e.cout));
                cmp(e.name, "Set",  8'(set1),    8'(e.set));
                cmp(e.name, "Ovf",  8'(ovf1),    8'(e.ovf));
            end
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic ain, input logic bin, input logic [1:0] op,
                         input logic cin, input logic less);
        @(negedge clk);
        rst = r; a_i = a; b_i = b; ain_i = ain; bin_i = bin;
        op_i = op; cin_i = cin; less_i = less;
    endtask

    task automatic add_vec(input string nm, input logic w8, input logic r,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic ain, input logic bin, input logic [1:0] op,
                           input logic cin, input logic less,
                           input logic [7:0] o, input logic co, input logic s, input logic v);
        vec_t x;
        x.name = nm; x.w8 = w8; x.rst = r; x.a = a; x.b = b; x.ain = ain; x.bin = bin;
        x.op = op; x.cin = cin; x.less = less; x.o = o; x.cout = co; x.set = s; x.ovf = v;
        vq.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t e;
        rst = 1'b1; a_i = '0; b_i = '0; ain_i = 0; bin_i = 0; op_i = 0; cin_i = 0; less_i = 0;

        //       name          w8 rst  A      B      Ain Bin Op  Cin Less  O      Co S  V
        add_vec("rst_w1",      0, 1, 8'h00, 8'h00, 0, 0, 2'd2, 0, 0, 8'h00, 0, 0, 0);
        add_vec("rst_w8",      1, 1, 8'h00, 8'h00, 0, 0, 2'd2, 0, 0, 8'h00, 0, 0, 0);
        add_vec("first_add",   0, 0, 8'h01, 8'h01, 0, 0, 2'd2, 0, 0, 8'h00, 1, 0, 1);
        add_vec("and_w1",      0, 0, 8'h01, 8'h00, 0, 0, 2'd0, 0, 0, 8'h00, 0, 1, 0);
        add_vec("or_w1",       0, 0, 8'h01, 8'h00, 0, 0, 2'd1, 0, 0, 8'h01, 0, 1, 0);
        add_vec("nor_w1",      0, 0, 8'h00, 8'h00, 1, 1, 2'd0, 0, 0, 8'h01, 1, 0, 1);
        add_vec("sub_w1",      0, 0, 8'h01, 8'h01, 0, 1, 2'd2, 1, 0, 8'h00, 1, 0, 0);
        add_vec("slt_w1",      0, 0, 8'h01, 8'h01, 0, 1, 2'd3, 1, 1, 8'h01, 1, 0, 0);
        add_vec("add_ovf_w8",  1, 0, 8'h7F, 8'h01, 0, 0, 2'd2, 0, 0, 8'h80, 0, 1, 1);
        add_vec("carry_wrap",  1, 0, 8'hFF, 8'h01, 0, 0, 2'd2, 0, 0, 8'h00, 1, 0, 0);
        add_vec("slt_w8_l1",   1, 0, 8'h03, 8'h05, 0, 1, 2'd3, 1, 1, 8'h01, 0, 1, 0);
        add_vec("slt_w8_l0",   1, 0, 8'h03, 8'h05, 0, 1, 2'd3, 1, 0, 8'h00, 0, 1, 0);

        // Reset rows get random operands; reset must mask them.
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            if (v.rst) begin
                v.a = 8'($urandom); v.b = 8'($urandom);
                v.ain = 1'($urandom); v.bin = 1'($urandom);
                v.op = 2'($urandom); v.cin = 1'($urandom); v.less = 1'($urandom);
            end
            drive(v.rst, v.a, v.b, v.ain, v.bin, v.op, v.cin, v.less);
            e.name = v.name; e.w8 = v.w8; e.o = v.o;
            e.cout = v.cout; e.set = v.set; e.ovf = v.ovf;
            sb.push_back(e);
            @(posedge clk); #1;
            check_sb();
        end

        // Random stream with a single-cycle reset in the middle; both widths checked.
        for (int i = 0; i < 40; i++) begin
            logic       r;
            logic [7:0] a, b;
            logic       ain, bin, cin, less;
            logic [1:0] op;
            r = (i == 20);
            a = 8'($urandom); b = 8'($urandom);
            ain = 1'($urandom); bin = 1'($urandom); cin = 1'($urandom); less = 1'($urandom);
            op = 2'($urandom);
            drive(r, a, b, ain, bin, op, cin, less);
            sb.push_back(model($sformatf("rnd%0d_w1", i), 1'b0, r, a, b, ain, bin, op, cin, less));
            sb.push_back(model($sformatf("rnd%0d_w8", i), 1'b1, r, a, b, ain, bin, op, cin, less));
            @(posedge clk); #1;
            check_sb();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
